// File: rtl/instr_fetch_decode.sv
// ----------------------------------------------------------------------------
// instr_fetch_decode
//   Front end of the x86-subset CPU. It fetches one instruction from byte
//   memory, one byte per read, starting at eip. It works out the instruction
//   length from the opcode and, where present, the ModRM byte. It then hands
//   the packed bytes to the ALU through a valid/ready handshake.
//
// Ports
//   clock, reset_n      system clock (rising edge), async active-low reset
//   fetch_start, eip    start a fetch at eip (sampled only while idle)
//   flush               abort any fetch in progress (taken jump/call/ret)
//   mem_rd, mem_addr    byte read request, held until mem_ack
//   mem_rdata, mem_ack  read data / completion (zero-wait allowed)
//   ope                 instruction bytes 0..3, byte 0 in the MSB lane
//   immidiate_data      instruction bytes 4..7, byte 4 in the MSB lane
//   num_of_ope          instruction length; 0 unless ope_valid
//   illegal             unsupported opcode/addressing; length forced to 1
//   ope_valid/ope_ready consumer handshake; outputs held until accepted
//   busy                fetch unit not idle
//
// state         | meaning
// --------------+------------------------------------------------------------
// S_IDLE        | waiting for fetch_start
// S_FETCH_OP    | reading opcode byte (byte 0)
// S_FETCH_MODRM | reading ModRM byte (byte 1) of 89/8b/83
// S_FETCH_REST  | reading immediate/displacement bytes up to the length
// S_DONE        | instruction presented, waiting for ope_ready
// ----------------------------------------------------------------------------
module instr_fetch_decode #(
    parameter int ADDR_W  = 32,
    parameter int MAX_LEN = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fetch_start,
    input  logic [ADDR_W-1:0] eip,
    input  logic              flush,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       ope,
    output logic [31:0]       immidiate_data,
    output logic [3:0]        num_of_ope,
    output logic              illegal,
    output logic              ope_valid,
    input  logic              ope_ready,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_OP,
        S_FETCH_MODRM,
        S_FETCH_REST,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [ADDR_W-1:0]        r_base;
    logic [3:0]               r_k;
    logic [3:0]               r_len;
    logic [3:0]               w_len_next;
    logic                     r_illegal;
    logic                     w_ill_next;
    logic                     w_capture;
    logic [8*MAX_LEN-1:0]     r_bytes;
    logic [7:0]               w_opcode;
    logic [1:0]               w_mod;
    logic [2:0]               w_rm;
    logic [3:0]               w_modrm_len;
    logic                     w_modrm_bad;
    logic                     w_fetching;

    assign w_opcode   = r_bytes[8*MAX_LEN-1 -: 8];
    assign w_mod      = mem_rdata[7:6];
    assign w_rm       = mem_rdata[2:0];
    assign w_fetching = (r_state == S_FETCH_OP) || (r_state == S_FETCH_MODRM) ||
                        (r_state == S_FETCH_REST);

    // Length implied by the ModRM byte while it is on mem_rdata. SIB forms
    // and the mod=00/rm=101 absolute disp32 form are not supported.
    always_comb begin
        w_modrm_len = (w_opcode == 8'h83) ? 4'd3 : 4'd2;
        w_modrm_bad = 1'b0;
        case (w_mod)
            2'b01:   w_modrm_len = w_modrm_len + 4'd1;
            2'b10:   w_modrm_len = w_modrm_len + 4'd4;
            default: w_modrm_len = w_modrm_len;
        endcase
        if ((w_mod != 2'b11) && (w_rm == 3'b100))
            w_modrm_bad = 1'b1;
        if ((w_mod == 2'b00) && (w_rm == 3'b101))
            w_modrm_bad = 1'b1;
    end

    always_comb begin
        w_next     = r_state;
        w_len_next = r_len;
        w_ill_next = r_illegal;
        w_capture  = 1'b0;
        // flush wins over everything, including an ack in the same cycle
        if (flush && (r_state != S_IDLE)) begin
            w_next     = S_IDLE;
            w_len_next = 4'd0;
            w_ill_next = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fetch_start) begin
                        w_next     = S_FETCH_OP;
                        w_len_next = 4'd0;
                        w_ill_next = 1'b0;
                    end
                end
                S_FETCH_OP: begin
                    if (mem_ack) begin
                        w_capture = 1'b1;
                        case (mem_rdata)
                            8'h55, 8'h53, 8'h5d, 8'hc3, 8'hc9: begin
                                w_len_next = 4'd1;
                                w_next     = S_DONE;
                            end
                            8'h6a, 8'h75, 8'heb: begin
                                w_len_next = 4'd2;
                                w_next     = S_FETCH_REST;
                            end
                            8'hb8, 8'he8: begin
                                w_len_next = 4'd5;
                                w_next     = S_FETCH_REST;
                            end
                            8'h89, 8'h8b, 8'h83: begin
                                w_next = S_FETCH_MODRM;
                            end
                            default: begin
                                w_ill_next = 1'b1;
                                w_len_next = 4'd1;
                                w_next     = S_DONE;
                            end
                        endcase
                    end
                end
                S_FETCH_MODRM: begin
                    if (mem_ack) begin
                        w_capture = 1'b1;
                        if (w_modrm_bad) begin
                            w_ill_next = 1'b1;
                            w_len_next = 4'd1;
                            w_next     = S_DONE;
                        end else begin
                            w_len_next = w_modrm_len;
                            w_next     = (w_modrm_len == 4'd2) ? S_DONE : S_FETCH_REST;
                        end
                    end
                end
                S_FETCH_REST: begin
                    if (mem_ack) begin
                        w_capture = 1'b1;
                        if ((r_k + 4'd1) == r_len)
                            w_next = S_DONE;
                    end
                end
                S_DONE: begin
                    if (ope_ready)
                        w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_k       <= 4'd0;
            r_len     <= 4'd0;
            r_illegal <= 1'b0;
            r_bytes   <= '0;
        end else begin
            r_state   <= w_next;
            r_len     <= w_len_next;
            r_illegal <= w_ill_next;
            if ((r_state == S_IDLE) && fetch_start) begin
                r_base  <= eip;
                r_k     <= 4'd0;
                r_bytes <= '0;
            end else if (flush && (r_state != S_IDLE)) begin
                r_k     <= 4'd0;
                r_bytes <= '0;
            end else if (w_capture) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (r_k == 4'(i))
                        r_bytes[8*(MAX_LEN-i)-1 -: 8] <= mem_rdata;
                end
                r_k <= r_k + 4'd1;
            end
        end
    end

    // Address arithmetic wraps naturally at ADDR_W bits.
    assign mem_rd         = w_fetching;
    assign mem_addr       = r_base + ADDR_W'(r_k);
    assign ope            = r_bytes[8*MAX_LEN-1 -: 32];
    assign immidiate_data = r_bytes[8*MAX_LEN-33 -: 32];
    assign ope_valid      = (r_state == S_DONE);
    assign num_of_ope     = (r_state == S_DONE) ? r_len : 4'd0;
    assign illegal        = r_illegal;
    assign busy           = (r_state != S_IDLE);

endmodule
